// File: rtl/mem_dump.sv
// mem_dump: SRAM readback engine. On a start request it reads a contiguous
// window of SRAM words (1-cycle read latency) and pushes each word into a
// downstream FIFO, stalling while the FIFO reports full, then pulses a
// completion flag for one cycle.
//
// Ports:
//   mem_dump_clk_i     clock, rising edge
//   mem_dump_rst_i     synchronous active-low reset
//   dump_start_i       start request, sampled only while idle
//   dump_base_addr_i   first SRAM word address, latched on start
//   dump_count_i       number of words (0..2^ADDRESS_WIDTH), latched on start
//   sram_data_i        SRAM read data
//   fifo_full_i        downstream FIFO full flag
//   sram_address_o     SRAM word address (always the current read pointer)
//   sram_cs_o          SRAM chip select (read issue cycle only)
//   sram_we_o          SRAM write enable, tied low
//   fifo_writeflag_o   FIFO write strobe
//   fifo_writedata_o   FIFO write data
//   busy_o             high while a dump is in progress
//   flag_readfinish_o  one-cycle completion pulse
//   words_sent_o       words accepted by the FIFO in the current/last dump
module mem_dump #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 13
) (
  input  logic                     mem_dump_clk_i,
  input  logic                     mem_dump_rst_i,
  input  logic                     dump_start_i,
  input  logic [ADDRESS_WIDTH-1:0] dump_base_addr_i,
  input  logic [ADDRESS_WIDTH:0]   dump_count_i,
  input  logic [DATA_WIDTH-1:0]    sram_data_i,
  input  logic                     fifo_full_i,
  output logic [ADDRESS_WIDTH-1:0] sram_address_o,
  output logic                     sram_cs_o,
  output logic                     sram_we_o,
  output logic                     fifo_writeflag_o,
  output logic [DATA_WIDTH-1:0]    fifo_writedata_o,
  output logic                     busy_o,
  output logic                     flag_readfinish_o,
  output logic [ADDRESS_WIDTH:0]   words_sent_o
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DATA,
    PUSH,
    FINISH
  } state_t;

  localparam logic [ADDRESS_WIDTH:0] CNT_ONE = {{ADDRESS_WIDTH{1'b0}}, 1'b1};

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [ADDRESS_WIDTH:0]   remaining_q;
  logic [ADDRESS_WIDTH:0]   words_sent_q;
  logic [DATA_WIDTH-1:0]    wdata_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (dump_start_i) begin
          state_d = (dump_count_i == '0) ? FINISH : ISSUE;
        end
      end
      ISSUE:  state_d = DATA;
      DATA:   state_d = PUSH;
      PUSH: begin
        if (!fifo_full_i) begin
          state_d = (remaining_q == CNT_ONE) ? FINISH : ISSUE;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mem_dump_clk_i) begin
    if (!mem_dump_rst_i) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      words_sent_q <= '0;
      wdata_q      <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (dump_start_i) begin
            addr_q       <= dump_base_addr_i;
            remaining_q  <= dump_count_i;
            words_sent_q <= '0;
          end
        end
        DATA: wdata_q <= sram_data_i;
        PUSH: begin
          if (!fifo_full_i) begin
            addr_q       <= addr_q + 1'b1;
            remaining_q  <= remaining_q - 1'b1;
            words_sent_q <= words_sent_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes are gated by the reset input itself so that a reset cycle never
  // touches the SRAM or the FIFO, even before the state register clears.
  assign sram_cs_o         = mem_dump_rst_i && (state_q == ISSUE);
  assign fifo_writeflag_o  = mem_dump_rst_i && (state_q == PUSH) && !fifo_full_i;
  assign sram_we_o         = 1'b0;
  assign sram_address_o    = addr_q;
  assign fifo_writedata_o  = wdata_q;
  assign busy_o            = (state_q != IDLE);
  assign flag_readfinish_o = (state_q == FINISH);
  assign words_sent_o      = words_sent_q;

endmodule

// File: tb/tb_mem_dump.sv
module tb_mem_dump;
  localparam int AW    = 13;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          full = 1'b0;
  logic [AW-1:0] base_in = '0;
  logic [AW:0]   count_in = '0;
  logic [DW-1:0] sram_rdata = '0;
  logic [AW-1:0] sram_addr;
  logic          sram_cs, sram_we, fifo_wr, busy, fin;
  logic [DW-1:0] fifo_wdata;
  logic [AW:0]   words_sent;

  logic [DW-1:0] mem [DEPTH];

  int n_cmp = 0;
  int n_err = 0;

  mem_dump #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .mem_dump_clk_i   (clk),
    .mem_dump_rst_i   (rst_n),
    .dump_start_i     (start),
    .dump_base_addr_i (base_in),
    .dump_count_i     (count_in),
    .sram_data_i      (sram_rdata),
    .fifo_full_i      (full),
    .sram_address_o   (sram_addr),
    .sram_cs_o        (sram_cs),
    .sram_we_o        (sram_we),
    .fifo_writeflag_o (fifo_wr),
    .fifo_writedata_o (fifo_wdata),
    .busy_o           (busy),
    .flag_readfinish_o(fin),
    .words_sent_o     (words_sent)
  );

  always #5 clk = ~clk;

  // SRAM model: one-cycle registered read.
  always @(posedge clk) if (sram_cs) sram_rdata <= mem[sram_addr];

  int edge_cnt = 0;
  int cyc_base = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int          c;
    logic [31:0] v;
  } ev_t;

  ev_t wr_q[$];
  ev_t cs_q[$];
  int  fin_q[$];
  bit  mon_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Record FIFO writes, SRAM reads and finish pulses mid-cycle, tagged with
  // the cycle number relative to the accepting edge (cycle 1 follows it).
  always @(negedge clk) begin
    if (mon_en) begin
      if (fifo_wr) wr_q.push_back('{edge_cnt - cyc_base + 1, fifo_wdata});
      if (sram_cs) cs_q.push_back('{edge_cnt - cyc_base + 1, 32'(sram_addr)});
      if (fin)     fin_q.push_back(edge_cnt - cyc_base + 1);
      if (sram_we) check("sram_we_zero", 64'(sram_we), 64'd0);
    end
  end

  task automatic run_dump(input logic [AW-1:0] b, input int n, input int pct,
                          input int fs, input int fe, input bit poke);
    bit            full_at[256];
    int            exp_wr[$];
    int            exp_cs[$];
    int            exp_fin;
    int            t, p;
    logic [AW-1:0] a;
    for (int i = 0; i < 256; i++) begin
      full_at[i] = (i < 150) && (($urandom_range(99) < pct) || (i >= fs && i <= fe));
    end
    // Reference timeline: each word costs issue, data, then push cycles;
    // the push repeats while the FIFO is full.
    t = 1;
    for (int k = 0; k < n; k++) begin
      exp_cs.push_back(t);
      p = t + 2;
      while (full_at[p]) p++;
      exp_wr.push_back(p);
      t = p + 1;
    end
    exp_fin = t;

    wr_q.delete(); cs_q.delete(); fin_q.delete();
    @(posedge clk); #1;
    base_in = b; count_in = (AW+1)'(n); start = 1'b1; full = 1'b0;
    @(posedge clk); #1;
    cyc_base = edge_cnt; mon_en = 1'b1;
    start = 1'b0; base_in = AW'($urandom); count_in = (AW+1)'($urandom);
    for (int c = 1; c <= exp_fin + 3; c++) begin
      full = full_at[c];
      if (poke) start = (c >= 2 && c <= 4);
      #1;
      check("busy", 64'(busy), 64'(c <= exp_fin));
      @(posedge clk); #1;
    end
    mon_en = 1'b0; full = 1'b0; start = 1'b0;

    check("n_writes", 64'(wr_q.size()), 64'(n));
    check("n_reads", 64'(cs_q.size()), 64'(n));
    for (int k = 0; k < n && k < wr_q.size() && k < cs_q.size(); k++) begin
      a = b + AW'(k);
      check("read_cycle", 64'(cs_q[k].c), 64'(exp_cs[k]));
      check("read_addr", 64'(cs_q[k].v), 64'(a));
      check("write_cycle", 64'(wr_q[k].c), 64'(exp_wr[k]));
      check("write_data", 64'(wr_q[k].v), 64'(mem[a]));
    end
    check("n_finish", 64'(fin_q.size()), 64'd1);
    if (fin_q.size() > 0) check("finish_cycle", 64'(fin_q[0]), 64'(exp_fin));
    check("words_sent", 64'(words_sent), 64'(n));
  endtask

  task automatic reset_mid(input int rc);
    wr_q.delete(); cs_q.delete(); fin_q.delete();
    @(posedge clk); #1;
    base_in = AW'($urandom); count_in = 4; start = 1'b1; full = 1'b0;
    @(posedge clk); #1;
    cyc_base = edge_cnt; mon_en = 1'b1; start = 1'b0;
    for (int c = 1; c < rc; c++) begin
      @(posedge clk); #1;
    end
    check("busy_before_reset", 64'(busy), 64'd1);
    rst_n = 1'b0; #1;
    check("rst_cycle_cs", 64'(sram_cs), 64'd0);
    check("rst_cycle_wr", 64'(fifo_wr), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_words_sent", 64'(words_sent), 64'd0);
    check("rst_addr", 64'(sram_addr), 64'd0);
    check("rst_wdata", 64'(fifo_wdata), 64'd0);
    repeat (12) @(posedge clk);
    #1;
    mon_en = 1'b0;
    check("rst_no_finish", 64'(fin_q.size()), 64'd0);
    check("rst_stays_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[16 + i] = 32'hA000_0000 + 32'(i);

    // Reset held with start asserted: everything stays quiet.
    rst_n = 1'b0; start = 1'b1; full = 1'b0; base_in = 13'h123; count_in = 5;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_fin", 64'(fin), 64'd0);
    check("reset_cs", 64'(sram_cs), 64'd0);
    check("reset_wr", 64'(fifo_wr), 64'd0);
    check("reset_we", 64'(sram_we), 64'd0);
    check("reset_addr", 64'(sram_addr), 64'd0);
    check("reset_wdata", 64'(fifo_wdata), 64'd0);
    check("reset_words", 64'(words_sent), 64'd0);
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_dump(13'h010, 4, 0, 0, -1, 1'b0);     // basic
    run_dump(13'h010, 4, 0, 6, 10, 1'b0);     // backpressure cycles 6..10
    run_dump(13'h1FFE, 4, 0, 0, -1, 1'b0);    // address wrap
    run_dump(AW'($urandom), 0, 0, 0, -1, 1'b0); // zero count
    run_dump(AW'($urandom), 2, 0, 0, -1, 1'b1); // start ignored while busy
    for (int r = 0; r < 6; r++) begin
      run_dump(AW'($urandom_range(DEPTH - 1)), $urandom_range(10), 30, 0, -1, 1'(r % 2));
    end
    run_dump(13'h1FFC, 8, 40, 0, -1, 1'b0);   // wrap under random stalls

    reset_mid(7);
    reset_mid(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_dump.md
# mem_dump

Memory readback engine: the read-direction counterpart of the FIFO-to-SRAM init path. On a start pulse it reads a contiguous window of the 32-bit SRAM word by word and pushes each word into a downstream FIFO, honouring the FIFO full flag. It then pulses a completion flag. While busy it owns the SRAM port; the same control mux that hands the SRAM to the micro or the init path selects this block's SRAM outputs.

## Interface

Parameters:
- DATA_WIDTH, 32, SRAM/FIFO word width
- ADDRESS_WIDTH, 13, SRAM word address width

Ports:
- mem_dump_clk_i  input  1  single clock; all logic on rising edge
- mem_dump_rst_i  input  1  reset, synchronous, active-low
- dump_start_i  input  1  start request; sampled only in IDLE
- dump_base_addr_i  input  ADDRESS_WIDTH  first SRAM address; latched on start
- dump_count_i  input  ADDRESS_WIDTH+1  number of words, 0..2^ADDRESS_WIDTH; latched on start
- sram_data_i  input  DATA_WIDTH  SRAM read data (from sram_data_o)
- fifo_full_i  input  1  downstream FIFO full flag
- sram_address_o  output  ADDRESS_WIDTH  SRAM address
- sram_cs_o  output  1  SRAM chip select
- sram_we_o  output  1  SRAM write enable; constant 0
- fifo_writeflag_o  output  1  FIFO write strobe, one word per cycle high
- fifo_writedata_o  output  DATA_WIDTH  FIFO write data
- busy_o  output  1  high whenever state is not IDLE
- flag_readfinish_o  output  1  one-cycle completion pulse
- words_sent_o  output  ADDRESS_WIDTH+1  words accepted by the FIFO in the current or last dump

## Operation

- FSM states: IDLE, ISSUE, DATA, PUSH, FINISH.
- IDLE: if dump_start_i=1, latch base into addr_q and count into remaining_q, and clear words_sent_o. If count=0, go to FINISH; otherwise go to ISSUE. If dump_start_i=0, stay in IDLE.
- ISSUE: sram_cs_o=1 and sram_address_o=addr_q. Go to DATA.
- DATA: sram_data_i is valid. Register it into fifo_writedata_o. Go to PUSH.
- PUSH: fifo_writeflag_o = !fifo_full_i. On an accepted write:
  - addr_q increments by 1, modulo 2^ADDRESS_WIDTH (so 0x1FFF wraps to 0x0000).
  - remaining_q decrements by 1.
  - words_sent_o increments by 1.
  - If remaining_q was 1, go to FINISH; otherwise go to ISSUE.
- PUSH while fifo_full_i=1: stay in PUSH, hold fifo_writedata_o, no write, no SRAM access.
- FINISH: flag_readfinish_o=1. Go to IDLE.
- dump_start_i is ignored in every state except IDLE. The next start is accepted no earlier than the cycle after FINISH.
- sram_cs_o=0 outside ISSUE. sram_address_o holds addr_q at all times.
- sram_we_o is tied 0, so the block never writes the SRAM.
- fifo_writeflag_o and sram_cs_o are forced 0 in any cycle where mem_dump_rst_i=0. This holds even though the state register only updates at the edge.

## Timing

- Reset (mem_dump_rst_i=0 at a rising edge) puts the block in IDLE with:
  - addr_q=0, remaining_q=0, words_sent_o=0, fifo_writedata_o=0
  - busy_o=0, flag_readfinish_o=0, sram_cs_o=0, fifo_writeflag_o=0, sram_we_o=0, sram_address_o=0
- Reset mid-dump aborts immediately, emits no finish pulse, and leaves the SRAM unmodified.
- SRAM read latency is 1 cycle: the address presented with cs in cycle N gives valid sram_data_i in cycle N+1.
- Start accepted at edge 0 gives:
  - ISSUE in cycle 1, DATA in cycle 2, first write strobe in cycle 3.
  - With no backpressure, word k is written in cycle 3+3k (3 cycles/word).
  - For n words, FINISH is in cycle 3n+1 and busy_o is high for cycles 1..3n+1.
- Each stall cycle (fifo_full_i=1 in PUSH) delays every subsequent event by exactly one cycle.
- Count 0: FINISH in cycle 1, with no sram_cs_o and no write.
- The FIFO samples fifo_writeflag_o/fifo_writedata_o on the same edge that advances the FSM. Each word is written exactly once, with no duplicates or drops.

## Test plan

- Reset: hold mem_dump_rst_i=0 with dump_start_i=1 and fifo_full_i=0 -> every output 0, busy_o=0, no strobe.
- Basic dump: SRAM[0x010..0x013]=0xA0000000..0xA0000003, base=0x010, count=4, FIFO never full -> strobes in cycles 3,6,9,12 carrying data 0xA0000000..0xA0000003 in order; finish pulse in cycle 13; words_sent_o=4; busy_o low from cycle 14.
- Backpressure: same setup, fifo_full_i=1 for cycles 6..10 -> the second word is held, written in cycle 11 exactly once; remaining strobes at cycles 14,17; finish at 18.
- Wrap: base=0x1FFE, count=4 -> SRAM addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001 in that order; words_sent_o=4.
- Zero count and ignored start: count=0 -> finish pulse in cycle 1 with no cs/strobe. A start pulsed during a 2-word dump -> ignored; only 2 words written.
- Reset mid-dump: assert reset in cycle 7 of a 4-word dump -> state IDLE after that edge, no strobe or cs in the reset cycle, no finish pulse, words_sent_o=0.
